// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, effective address base + sext(offset),
// single-cycle memory issue. Optional range check enabled by LSU_RANGE_CHECK_EN.
`timescale 1ns/1ps
module load_store_unit #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 31
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_base,
    input  logic [15:0]       req_offset,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e              state_q, state_d;
    logic                write_q, write_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_fault_q, resp_fault_d;
    logic [31:0]         resp_rdata_q, resp_rdata_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic                mem_re_q, mem_re_d;

    logic [31:0] ea;
    logic        ea_in_depth;
    logic        in_range;

    assign ea          = req_base + {{16{req_offset[15]}}, req_offset};
    assign ea_in_depth = (ea < DEPTH);

`ifdef LSU_RANGE_CHECK_EN
    assign in_range = ea_in_depth;
`else
    // Without the check every request is issued; high address bits are dropped.
    logic unused_ea_in_depth;
    assign unused_ea_in_depth = ea_in_depth;
    assign in_range           = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        resp_valid_d = resp_valid_q;
        resp_fault_d = resp_fault_q;
        resp_rdata_d = resp_rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    write_d = req_write;
                    if (in_range) begin
                        state_d     = StIssue;
                        mem_addr_d  = ea[ADDR_W-1:0];
                        mem_wdata_d = req_wdata;
                        mem_we_d    = req_write;
                        mem_re_d    = !req_write;
                    end else begin
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                        resp_rdata_d = '0;
                    end
                end
            end
            StIssue: begin
                // Memory responded on the falling edge inside this cycle.
                state_d      = StResp;
                resp_valid_d = 1'b1;
                resp_fault_d = 1'b0;
                resp_rdata_d = write_q ? 32'h0 : mem_rdata;
            end
            StResp: begin
                if (resp_ready) begin
                    state_d      = StIdle;
                    resp_valid_d = 1'b0;
                    resp_fault_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        req_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            write_q      <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_fault = resp_fault_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign mem_re     = mem_re_q;

endmodule
